// File: rtl/lock_pkg.sv
// Shared types and helpers for the hardware-lock key loader.
package lock_pkg;

    localparam int unsigned CHK_W     = 8;
    localparam int unsigned FAIL_W    = 4;
    // Widest key the checksum helper folds; narrower keys are zero-extended.
    localparam int unsigned MAX_KEY_W = 512;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_KEY = 3'd1,
        ST_SHIFT_CHK = 3'd2,
        ST_CHECK     = 3'd3,
        ST_LOADED    = 3'd4,
        ST_LOCKOUT   = 3'd5
    } state_e;

    // XOR of all bytes; zero padding bytes do not change the result.
    function automatic logic [CHK_W-1:0] xor_fold(input logic [MAX_KEY_W-1:0] d);
        logic [CHK_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(MAX_KEY_W / CHK_W); i++) begin
            acc = acc ^ d[i*CHK_W +: CHK_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/lock_key_loader_if.sv
// Provisioning-side serial inputs and parallel key-bus outputs of the loader.
interface lock_key_loader_if #(
    parameter int unsigned KEY_WIDTH = 64
);
    logic                 key_start;
    logic                 key_bit_valid;
    logic                 key_bit;
    logic                 key_clear;
    logic [KEY_WIDTH-1:0] key_out;
    logic                 key_ready;
    logic                 key_busy;
    logic                 key_err;
    logic                 locked_out;
    logic [3:0]           fail_cnt;

    modport master (
        output key_start, key_bit_valid, key_bit, key_clear,
        input  key_out, key_ready, key_busy, key_err, locked_out, fail_cnt
    );

    modport slave (
        input  key_start, key_bit_valid, key_bit, key_clear,
        output key_out, key_ready, key_busy, key_err, locked_out, fail_cnt
    );
endinterface

// File: rtl/lock_shift_reg.sv
// Serial-in/parallel-out register, LSB received first, with synchronous clear.
module lock_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         shift_i,
    input  logic         bit_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (shift_i) begin
            data_d = {bit_i, data_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/lock_key_loader.sv
// Receives the unlock key serially, verifies its XOR checksum and drives the
// parallel key bus; repeated bad loads latch a lockout that only reset clears.
module lock_key_loader
    import lock_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 64,
    parameter int unsigned MAX_FAIL  = 3,
    parameter int unsigned CNT_W     = 7
) (
    input logic              clk,
    input logic              rst,
    lock_key_loader_if.slave kif
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0] key_out_q, key_out_d;
    logic                 key_ready_q, key_ready_d;
    logic                 key_busy_q, key_busy_d;
    logic                 key_err_q, key_err_d;
    logic                 locked_out_q, locked_out_d;
    logic [FAIL_W-1:0]    fail_cnt_q, fail_cnt_d;

    logic                 sr_clr;
    logic                 key_shift;
    logic                 chk_shift;
    logic [KEY_WIDTH-1:0] key_sr;
    logic [CHK_W-1:0]     chk_sr;
    logic                 sum_ok;
    logic [FAIL_W-1:0]    fail_inc;

    lock_shift_reg #(.W(KEY_WIDTH)) u_key_sr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sr_clr),
        .shift_i(key_shift),
        .bit_i  (kif.key_bit),
        .data_o (key_sr)
    );

    lock_shift_reg #(.W(CHK_W)) u_chk_sr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sr_clr),
        .shift_i(chk_shift),
        .bit_i  (kif.key_bit),
        .data_o (chk_sr)
    );

    assign sum_ok   = (xor_fold(MAX_KEY_W'(key_sr)) == chk_sr);
    assign fail_inc = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + FAIL_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_out_d   = key_out_q;
        key_ready_d = key_ready_q;
        fail_cnt_d  = fail_cnt_q;
        key_err_d   = 1'b0;
        sr_clr      = 1'b0;
        key_shift   = 1'b0;
        chk_shift   = 1'b0;

        // Zeroization wins over every other request outside lockout.
        if (state_q != ST_LOCKOUT && kif.key_clear) begin
            state_d     = ST_IDLE;
            key_out_d   = '0;
            key_ready_d = 1'b0;
            sr_clr      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOADED: begin
                    if (kif.key_start) begin
                        state_d     = ST_SHIFT_KEY;
                        cnt_d       = '0;
                        key_out_d   = '0;
                        key_ready_d = 1'b0;
                        sr_clr      = 1'b1;
                    end
                end
                ST_SHIFT_KEY: begin
                    if (kif.key_start) begin
                        cnt_d  = '0;
                        sr_clr = 1'b1;
                    end else if (kif.key_bit_valid) begin
                        key_shift = 1'b1;
                        if (cnt_q == CNT_W'(KEY_WIDTH - 1)) begin
                            state_d = ST_SHIFT_CHK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_SHIFT_CHK: begin
                    // Counter parks at CHK_W for one cycle so the result lands two edges after the last bit.
                    if (kif.key_start) begin
                        state_d = ST_SHIFT_KEY;
                        cnt_d   = '0;
                        sr_clr  = 1'b1;
                    end else if (cnt_q == CNT_W'(CHK_W)) begin
                        state_d = ST_CHECK;
                    end else if (kif.key_bit_valid) begin
                        chk_shift = 1'b1;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (sum_ok) begin
                        key_out_d   = key_sr;
                        key_ready_d = 1'b1;
                        fail_cnt_d  = '0;
                        state_d     = ST_LOADED;
                    end else begin
                        key_err_d  = 1'b1;
                        fail_cnt_d = fail_inc;
                        state_d    = (fail_inc == FAIL_W'(MAX_FAIL)) ? ST_LOCKOUT : ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    key_out_d   = '0;
                    key_ready_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        key_busy_d   = (state_d == ST_SHIFT_KEY) || (state_d == ST_SHIFT_CHK) ||
                       (state_d == ST_CHECK);
        locked_out_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            key_out_q    <= '0;
            key_ready_q  <= 1'b0;
            key_busy_q   <= 1'b0;
            key_err_q    <= 1'b0;
            locked_out_q <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_out_q    <= key_out_d;
            key_ready_q  <= key_ready_d;
            key_busy_q   <= key_busy_d;
            key_err_q    <= key_err_d;
            locked_out_q <= locked_out_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign kif.key_out    = key_out_q;
    assign kif.key_ready  = key_ready_q;
    assign kif.key_busy   = key_busy_q;
    assign kif.key_err    = key_err_q;
    assign kif.locked_out = locked_out_q;
    assign kif.fail_cnt   = fail_cnt_q;

endmodule

// File: doc/lock_key_loader.md
Name: lock_key_loader

Overview:
- Key-provisioning end of the hardware-lock interface: receives the unlock key serially from the external provisioning pin and drives the parallel key bus consumed by the lock modules in PC, register file and ALU.
- Verifies an 8-bit checksum before releasing the key, holds the key stable until cleared, and enforces a lockout after repeated bad loads.
- Sits at the core top level between the provisioning pads and the key inputs of the locked datapath blocks.

Parameters:
- KEY_WIDTH, 64, key bus width in bits; must be a multiple of 8, minimum 8.
- MAX_FAIL, 3, consecutive checksum failures that trigger lockout; range 1..15.
- CNT_W, 7, width of the bit counter; must satisfy 2^CNT_W > KEY_WIDTH.

Ports:
- clk, input, 1, core clock.
- rst, input, 1, asynchronous active-high reset.
- key_start, input, 1, single-cycle pulse that begins a load frame.
- key_bit_valid, input, 1, qualifies key_bit this cycle.
- key_bit, input, 1, serial data bit, LSB first.
- key_clear, input, 1, zeroization request.
- key_out, output, KEY_WIDTH, key bus to the lock modules.
- key_ready, output, 1, key_out holds a verified key.
- key_busy, output, 1, a frame is in progress.
- key_err, output, 1, one-cycle pulse on checksum failure.
- locked_out, output, 1, lockout is active.
- fail_cnt, output, 4, count of consecutive failures.

Behaviour:
- Reset values (rst high, asynchronous): state IDLE; key_out = 0; key_ready, key_busy, key_err and locked_out = 0; fail_cnt = 0; shift register = 0.
- States: IDLE, SHIFT_KEY, SHIFT_CHK, CHECK, LOADED, LOCKOUT.
- IDLE or LOADED, key_start=1:
  - go to SHIFT_KEY and clear the bit counter.
  - key_out is forced to 0 and key_ready to 0 on the same edge, so no stale or partial key is ever visible.
- SHIFT_KEY:
  - each cycle with key_bit_valid=1, shift key_bit into the key shift register (bit 0 is received first) and increment the counter.
  - after KEY_WIDTH bits, go to SHIFT_CHK with the counter cleared.
  - cycles with key_bit_valid=0 are ignored; there is no timeout.
- SHIFT_CHK: shift 8 bits the same way, LSB first, then go to CHECK.
- CHECK (exactly one cycle): the expected checksum is the XOR of all KEY_WIDTH/8 key bytes.
  - Match: key_out <= shift register, key_ready <= 1, fail_cnt <= 0, go to LOADED.
  - Mismatch: key_out stays 0, key_err pulses for one cycle, fail_cnt increments. If the new fail_cnt equals MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- Latency: if the last checksum bit is sampled at edge E, key_ready and key_out update at edge E+2.
- key_busy = 1 in SHIFT_KEY, SHIFT_CHK and CHECK.
- key_start while busy (SHIFT_*): restarts the frame; the counter is cleared and the partial data discarded. This does not count as a failure.
- key_start during CHECK: ignored.
- key_clear (any state except LOCKOUT):
  - next edge: key_out = 0, key_ready = 0, shift register = 0, state = IDLE. fail_cnt is preserved.
  - key_clear has priority over key_start and key_bit_valid in the same cycle.
- LOCKOUT:
  - locked_out = 1, key_out = 0.
  - all inputs are ignored, including key_clear; exit only via rst.
- fail_cnt saturates at 15; it is never compared while in LOCKOUT.
- key_bit_valid in IDLE, LOADED or LOCKOUT: ignored.

Decomposition:
- Shared package lock_pkg:
  - state enum (3-bit encoding).
  - CHK_W = 8 constant.
  - the XOR-fold checksum function.
- One sub-module, lock_shift_reg: a parameterised serial-in/parallel-out register with clear, reused for the key and checksum fields.
- FSM, counter and fail logic stay in lock_key_loader.

Test Plan:
- Good load: KEY_WIDTH=64, key 0x0123456789ABCDEF, checksum 0x00 → two cycles after the last bit, key_out=0x0123456789ABCDEF, key_ready=1, fail_cnt=0, key_busy=0.
- Bad checksum: same key with checksum 0x01 → key_err is a 1-cycle pulse, key_out=0, fail_cnt=1, state IDLE.
- Lockout: three consecutive bad frames → locked_out=1 after the third. A following good frame and key_clear have no effect, key_out stays 0. rst → all outputs 0.
- Restart mid-frame: key_start after 20 key bits, then a full good frame with key 0x00000000000000A3 and checksum 0xA3 → key_out=0xA3, no key_err.
- Reload/clear: in LOADED, key_start → key_out=0 on the next edge. key_clear asserted together with key_bit_valid → IDLE, key_out=0, fail_cnt unchanged.
- Gapped input: key_bit_valid toggled 1/0 every cycle over a good frame → same result as the contiguous case; async rst asserted mid-frame clears all outputs without waiting for a clock edge.
